// File: rtl/accumulator_binary_if.sv
// Handshake bundle for accumulator_binary.
// Carries the operation channel (input_*) and the result channel (output_*).
//   master : operation producer / result consumer (drives operations, takes results)
//   slave  : the accumulator itself
interface accumulator_binary_if #(
    parameter int unsigned WORD_WIDTH = 8
);
    // Operation channel
    logic                  input_valid;
    logic                  input_ready;
    logic                  input_add_sub;
    logic                  input_carry_in;
    logic                  input_load;
    logic                  input_clear;
    logic [WORD_WIDTH-1:0] input_operand;

    // Result channel
    logic                  output_valid;
    logic                  output_ready;
    logic [WORD_WIDTH-1:0] output_value;
    logic                  output_carry_out;
    logic                  output_overflow;
    logic                  output_overflow_sticky;

    modport master (
        output input_valid,
        input  input_ready,
        output input_add_sub,
        output input_carry_in,
        output input_load,
        output input_clear,
        output input_operand,
        input  output_valid,
        output output_ready,
        input  output_value,
        input  output_carry_out,
        input  output_overflow,
        input  output_overflow_sticky
    );

    modport slave (
        input  input_valid,
        output input_ready,
        input  input_add_sub,
        input  input_carry_in,
        input  input_load,
        input  input_clear,
        input  input_operand,
        output output_valid,
        input  output_ready,
        output output_value,
        output output_carry_out,
        output output_overflow,
        output output_overflow_sticky
    );
endinterface

// File: rtl/accumulator_binary.sv
// Binary add/subtract accumulator with valid/ready handshake on both sides.
// One accepted operation per cycle, result registered on the accepting edge.
//
// Parameters:
//   WORD_WIDTH    : accumulator/operand width in bits (>= 2)
//   INITIAL_VALUE : accumulator value after reset and after clear
//
// Ports:
//   clock   : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : accumulator_binary_if.slave
//             input_valid/input_ready      operation handshake
//             input_add_sub                0 = add, 1 = subtract
//             input_carry_in               carry (add) / borrow (subtract) into bit 0
//             input_load / input_clear     load operand / return to INITIAL_VALUE
//             input_operand                operand B
//             output_valid/output_ready    result handshake
//             output_value                 accumulator value
//             output_carry_out             carry out of MSB (1 = no borrow on subtract)
//             output_overflow              signed overflow of last operation
//             output_overflow_sticky       OR of overflows since last clear/load
//
// Build option:
//   ACCUMULATOR_BINARY_SATURATE_EN : when defined, a signed overflow stores the signed
//                                    extreme instead of the wrapped value.
module accumulator_binary #(
    parameter int unsigned                WORD_WIDTH    = 8,
    parameter logic [WORD_WIDTH-1:0]      INITIAL_VALUE = '0
) (
    input logic                 clock,
    input logic                 reset_n,
    accumulator_binary_if.slave bus
);

    localparam int unsigned W = WORD_WIDTH;

    logic [W-1:0] value_q, value_d;
    logic         valid_q, valid_d;
    logic         carry_q, carry_d;
    logic         ovf_q, ovf_d;
    logic         sticky_q, sticky_d;

    logic         accept;
    logic [W-1:0] operand_b;
    logic         carry_b;
    logic [W:0]   sum_full;
    logic [W-1:0] sum_low;
    logic         carry_msb;
    logic         ovf_arith;
    logic [W-1:0] arith_value;

    assign bus.input_ready = !valid_q || bus.output_ready;
    assign accept          = bus.input_valid && bus.input_ready;

    // Subtract is acc + ~B + ~borrow, so a single adder serves both operations.
    assign operand_b = bus.input_add_sub ? ~bus.input_operand : bus.input_operand;
    assign carry_b   = bus.input_add_sub ? ~bus.input_carry_in : bus.input_carry_in;

    assign sum_full = {1'b0, value_q} + {1'b0, operand_b} + {{W{1'b0}}, carry_b};

    // Separate sum of the low W-1 bits recovers the carry into the MSB.
    assign sum_low   = {1'b0, value_q[W-2:0]} + {1'b0, operand_b[W-2:0]}
                     + {{(W-1){1'b0}}, carry_b};
    assign carry_msb = sum_low[W-1];
    assign ovf_arith = carry_msb ^ sum_full[W];

`ifdef ACCUMULATOR_BINARY_SATURATE_EN
    // A wrapped result with MSB set means the true result was too positive.
    always_comb begin
        arith_value = sum_full[W-1:0];
        if (ovf_arith) begin
            arith_value = sum_full[W-1] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
        end
    end
`else
    assign arith_value = sum_full[W-1:0];
`endif

    always_comb begin
        value_d  = value_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        sticky_d = sticky_q;
        valid_d  = valid_q;

        if (accept) begin
            valid_d = 1'b1;
            if (bus.input_clear) begin
                value_d  = INITIAL_VALUE;
                carry_d  = 1'b0;
                ovf_d    = 1'b0;
                sticky_d = 1'b0;
            end else if (bus.input_load) begin
                value_d  = bus.input_operand;
                carry_d  = 1'b0;
                ovf_d    = 1'b0;
                sticky_d = 1'b0;
            end else begin
                value_d  = arith_value;
                carry_d  = sum_full[W];
                ovf_d    = ovf_arith;
                sticky_d = sticky_q | ovf_arith;
            end
        end else if (bus.output_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value_q  <= INITIAL_VALUE;
            valid_q  <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            value_q  <= value_d;
            valid_q  <= valid_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.output_valid           = valid_q;
    assign bus.output_value           = value_q;
    assign bus.output_carry_out       = carry_q;
    assign bus.output_overflow        = ovf_q;
    assign bus.output_overflow_sticky = sticky_q;

endmodule

// File: tb/tb_accumulator_binary.sv
// Directed self-checking bench for accumulator_binary (WORD_WIDTH = 8, INITIAL_VALUE = 0).
// Expected values are hand-computed; saturating expectations follow
// ACCUMULATOR_BINARY_SATURATE_EN when that macro is defined for the build.
module tb_accumulator_binary;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    accumulator_binary_if #(.WORD_WIDTH(8)) bus ();

    accumulator_binary #(
        .WORD_WIDTH    (8),
        .INITIAL_VALUE (8'h00)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic [7:0] val, input logic co,
                               input logic ov, input logic st);
        check_eq({tag, " value"}, 32'(bus.output_value), 32'(val));
        check_eq({tag, " carry"}, 32'(bus.output_carry_out), 32'(co));
        check_eq({tag, " ovf"}, 32'(bus.output_overflow), 32'(ov));
        check_eq({tag, " sticky"}, 32'(bus.output_overflow_sticky), 32'(st));
    endtask

    // Offer one operation with output_ready high (always accepted), then sample mid-cycle.
    task automatic do_op(input logic sub, input logic cin, input logic ld, input logic clr,
                         input logic [7:0] operand);
        @(negedge clock);
        bus.input_add_sub  = sub;
        bus.input_carry_in = cin;
        bus.input_load     = ld;
        bus.input_clear    = clr;
        bus.input_operand  = operand;
        bus.input_valid    = 1'b1;
        bus.output_ready   = 1'b1;
        @(posedge clock);
        #1;
        bus.input_valid = 1'b0;
        bus.input_load  = 1'b0;
        bus.input_clear = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n             = 1'b0;
        bus.input_valid     = 1'b0;
        bus.input_add_sub   = 1'b0;
        bus.input_carry_in  = 1'b0;
        bus.input_load      = 1'b0;
        bus.input_clear     = 1'b0;
        bus.input_operand   = 8'h00;
        bus.output_ready    = 1'b1;

        #2;
        check_eq("reset valid", 32'(bus.output_valid), 32'd0);
        check_flags("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // add 0x05 + carry_in 1
        do_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h05);
        check_eq("add5 valid", 32'(bus.output_valid), 32'd1);
        check_flags("add5", 8'h06, 1'b0, 1'b0, 1'b0);

        // positive overflow
        do_op(1'b0, 1'b0, 1'b1, 1'b0, 8'h7F);
        check_flags("load7f", 8'h7F, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
`ifdef ACCUMULATOR_BINARY_SATURATE_EN
        check_flags("posovf", 8'h7F, 1'b0, 1'b1, 1'b1);
`else
        check_flags("posovf", 8'h80, 1'b0, 1'b1, 1'b1);
`endif

        // negative overflow with carry out
        do_op(1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
        check_flags("load80", 8'h80, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 1'b0, 1'b0, 1'b0, 8'h80);
`ifdef ACCUMULATOR_BINARY_SATURATE_EN
        check_flags("negovf", 8'h80, 1'b1, 1'b1, 1'b1);
`else
        check_flags("negovf", 8'h00, 1'b1, 1'b1, 1'b1);
`endif

        // subtract with borrow behaviour
        do_op(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        do_op(1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
        check_flags("sub1", 8'hFF, 1'b0, 1'b0, 1'b0);
        do_op(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check_flags("sub0b", 8'hFE, 1'b1, 1'b0, 1'b0);

        // Backpressure: hold a result, offer adds, then stream 10 back-to-back.
        do_op(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        bus.output_ready   = 1'b0;
        bus.input_add_sub  = 1'b0;
        bus.input_carry_in = 1'b0;
        bus.input_operand  = 8'h01;
        bus.input_valid    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq("stall ready", 32'(bus.input_ready), 32'd0);
            check_eq("stall valid", 32'(bus.output_valid), 32'd1);
            check_eq("stall value", 32'(bus.output_value), 32'h00);
        end
        bus.output_ready = 1'b1;
        #1;
        check_eq("release ready", 32'(bus.input_ready), 32'd1);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock);
            #1;
            if (k == 10) bus.input_valid = 1'b0;
            @(negedge clock);
            check_eq("stream value", 32'(bus.output_value), 32'(k));
        end
        check_eq("stream valid", 32'(bus.output_valid), 32'd1);
        @(negedge clock);
        check_eq("drain valid", 32'(bus.output_valid), 32'd0);
        check_eq("drain value", 32'(bus.output_value), 32'h0A);

        // clear beats load; both wipe the flags
        do_op(1'b0, 1'b0, 1'b1, 1'b0, 8'h7F);
        do_op(1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
        check_eq("pre-clear sticky", 32'(bus.output_overflow_sticky), 32'd1);
        do_op(1'b0, 1'b0, 1'b1, 1'b1, 8'h33);
        check_flags("clrload", 8'h00, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while a flagged result is held.
        do_op(1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
        do_op(1'b0, 1'b0, 1'b0, 1'b0, 8'h80);
        bus.output_ready = 1'b0;
        @(posedge clock);
        #2;
        check_eq("held valid", 32'(bus.output_valid), 32'd1);
        check_eq("held carry", 32'(bus.output_carry_out), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("async valid", 32'(bus.output_valid), 32'd0);
        check_flags("async", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        do_op(1'b0, 1'b0, 1'b0, 1'b0, 8'h03);
        check_eq("post-reset valid", 32'(bus.output_valid), 32'd1);
        check_flags("post-reset", 8'h03, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog: report and stop if the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
